uni_arbiter: RTL
================

UNI_ARBITER -- requirements
Module: uni_arbiter

Interface
REQ-001 Parameter UNI_ADDR_WIDTH, default 32, address width of every uni port.
REQ-002 Parameter UNI_DATA_WIDTH, default 128, wdata/rdata width of every uni port.
REQ-003 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  asynchronous, active-high reset.
REQ-005 Port UniIf_S0  uni_if.Slave  uni_if  requester 0 (instruction cache); fields valid, ready, reqtyp, addr, size, cachable, wdata, rdata.
REQ-006 Port UniIf_S1  uni_if.Slave  uni_if  requester 1 (data cache); same fields as UniIf_S0.
REQ-007 Port UniIf_M  uni_if.Master  uni_if  single downstream request port, feeding the uni-to-AXI bridge.

Function
REQ-008 Requester protocol: each requester SHALL hold valid and all request fields stable from assertion until the cycle it sees ready=1, and SHALL drop valid in the following cycle.
REQ-009 The block SHALL implement a three-state FSM: IDLE, GNT0, GNT1.
REQ-010 IDLE: UniIf_M.valid=0, both requester readys=0, no request fields forwarded.
REQ-011 IDLE -> GNT0 when only S0.valid=1; IDLE -> GNT1 when only S1.valid=1.
REQ-012 IDLE, both valid: grant the requester not recorded in the last-served register (lst); lst=0 -> GNT1, lst=1 -> GNT0.
REQ-013 Grant latency: a request first presented in IDLE SHALL appear on UniIf_M.valid exactly one cycle later.
REQ-014 GNTn: UniIf_M.valid, reqtyp, addr, size, cachable and wdata SHALL equal Sn's fields combinationally.
REQ-015 GNTn: Sn.ready SHALL equal UniIf_M.ready combinationally; the other requester's ready SHALL be 0.
REQ-016 UniIf_M.rdata SHALL be broadcast unmodified to S0.rdata and S1.rdata in all states.
REQ-017 GNTn with UniIf_M.ready=1: next state IDLE, lst <= n, in the same edge.
REQ-018 GNTn with UniIf_M.ready=0: stay in GNTn regardless of the other requester's valid; no preemption.
REQ-019 GNTn with Sn.valid=0 before completion (protocol violation): stay in GNTn; UniIf_M.valid follows Sn.valid.
REQ-020 After every completion the FSM SHALL spend at least one cycle in IDLE, guaranteeing the granted requester's dropped valid is sampled and the downstream ready pulse has cleared.
REQ-021 A requester whose valid rises while the other is granted SHALL be granted on the first IDLE cycle after that transaction completes, provided the completing requester is not re-requesting; otherwise REQ-012 applies.
REQ-022 Round-robin fairness: under continuous contention the two requesters SHALL be served alternately; no requester waits more than one foreign transaction.
REQ-023 Read and write reqtyp SHALL be forwarded identically; the block SHALL NOT decode reqtyp, size or cachable.

Reset
REQ-024 i_rst=1 SHALL immediately, without a clock edge, force state=IDLE and lst=1, so S0 wins the first tie.
REQ-025 During reset and in the first cycle after release, UniIf_M.valid, S0.ready and S1.ready SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the grant; no ready is returned for the abandoned request.

Verification
REQ-027 Single read: S0.valid=1, reqtyp=READ, addr=0x8000_0000 at cycle 0; M.ready pulses at cycle 5 with rdata=0x1122..FF -> M.valid=1 on cycles 1-5; S0.ready=1 at cycle 5 only; S0.rdata=0x1122..FF; state IDLE at cycle 6.
REQ-028 Tie after reset: S0 and S1 valid at cycle 0 -> GNT0 at cycle 1, M.addr = S0.addr; after S0 ready and drop, S1 is granted with no extra idle beyond REQ-020.
REQ-029 Continuous contention: both requesters re-request immediately for 6 transactions -> grant order 0,1,0,1,0,1; S1.ready never asserts while GNT0.
REQ-030 No preemption: S1.valid rises during GNT0 with S1 addr=0x8000_1000 -> M.addr stays at S0's value until S0.ready, then 0x8000_1000 appears.
REQ-031 Reset mid-op: i_rst=1 while in GNT1 with M.ready=0 -> same cycle M.valid=0, S1.ready=0; after release with both valid, S0 is granted first.
REQ-032 Write forwarding: S1 write, cachable=1, wdata=128'hA5..A5 -> M.reqtyp=WRITE, M.cachable=1, M.wdata=128'hA5..A5 throughout GNT1.

Source files
------------

// File: rtl/uni_arbiter_if.sv
// ============================================================================
// Module   : uni_if
// Brief    : Uni request/response bundle shared by cache requesters and bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uni_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) ();
    logic                  valid;
    logic                  ready;
    logic                  reqtyp;     // 0 = read, 1 = write
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic                  cachable;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport Master (
        output valid, reqtyp, addr, size, cachable, wdata,
        input  ready, rdata
    );

    modport Slave (
        input  valid, reqtyp, addr, size, cachable, wdata,
        output ready, rdata
    );
endinterface

`default_nettype wire

// File: rtl/uni_arbiter.sv
// ============================================================================
// Module   : uni_arbiter
// Brief    : Round-robin arbiter merging I-cache and D-cache uni ports onto one.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uni_arbiter #(
    parameter int UNI_ADDR_WIDTH = 32,
    parameter int UNI_DATA_WIDTH = 128
) (
    input  logic   i_clk,
    input  logic   i_rst,
    uni_if.Slave   UniIf_S0,
    uni_if.Slave   UniIf_S1,
    uni_if.Master  UniIf_M
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   lst_q,   lst_d;

    logic                      w_valid;
    logic                      w_reqtyp;
    logic [UNI_ADDR_WIDTH-1:0] w_addr;
    logic [2:0]                w_size;
    logic                      w_cachable;
    logic [UNI_DATA_WIDTH-1:0] w_wdata;
    logic                      w_ready0;
    logic                      w_ready1;

    // lst resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            lst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            lst_q   <= lst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lst_d   = lst_q;
        case (state_q)
            ST_IDLE: begin
                if (UniIf_S0.valid && UniIf_S1.valid) begin
                    state_d = lst_q ? ST_GNT0 : ST_GNT1;
                end else if (UniIf_S0.valid) begin
                    state_d = ST_GNT0;
                end else if (UniIf_S1.valid) begin
                    state_d = ST_GNT1;
                end
            end
            // A grant is only released by the downstream ready; no preemption.
            ST_GNT0: begin
                if (UniIf_M.ready) begin
                    state_d = ST_IDLE;
                    lst_d   = 1'b0;
                end
            end
            ST_GNT1: begin
                if (UniIf_M.ready) begin
                    state_d = ST_IDLE;
                    lst_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_valid    = 1'b0;
        w_reqtyp   = 1'b0;
        w_addr     = '0;
        w_size     = '0;
        w_cachable = 1'b0;
        w_wdata    = '0;
        w_ready0   = 1'b0;
        w_ready1   = 1'b0;
        case (state_q)
            ST_GNT0: begin
                w_valid    = UniIf_S0.valid;
                w_reqtyp   = UniIf_S0.reqtyp;
                w_addr     = UniIf_S0.addr;
                w_size     = UniIf_S0.size;
                w_cachable = UniIf_S0.cachable;
                w_wdata    = UniIf_S0.wdata;
                w_ready0   = UniIf_M.ready;
            end
            ST_GNT1: begin
                w_valid    = UniIf_S1.valid;
                w_reqtyp   = UniIf_S1.reqtyp;
                w_addr     = UniIf_S1.addr;
                w_size     = UniIf_S1.size;
                w_cachable = UniIf_S1.cachable;
                w_wdata    = UniIf_S1.wdata;
                w_ready1   = UniIf_M.ready;
            end
            default: ;
        endcase
    end

    assign UniIf_M.valid    = w_valid;
    assign UniIf_M.reqtyp   = w_reqtyp;
    assign UniIf_M.addr     = w_addr;
    assign UniIf_M.size     = w_size;
    assign UniIf_M.cachable = w_cachable;
    assign UniIf_M.wdata    = w_wdata;

    assign UniIf_S0.ready   = w_ready0;
    assign UniIf_S1.ready   = w_ready1;

    // Read data is broadcast; each requester qualifies it with its own ready.
    assign UniIf_S0.rdata   = UniIf_M.rdata;
    assign UniIf_S1.rdata   = UniIf_M.rdata;

endmodule

`default_nettype wire
